// File: rtl/alien_bullet_pool.sv
// Pool of downward-travelling alien bullets: allocation, per-frame motion, hit/exit frees, pixel output.
// Optional x zigzag when ALIEN_BULLET_ZIGZAG_EN is defined.
module alien_bullet_pool #(
    parameter int unsigned          SCREEN_CORDW = 16,
    parameter int unsigned          COLR_BITS    = 4,
    parameter int unsigned          N_SLOTS      = 4,
    parameter int unsigned          BULLET_W     = 4,
    parameter int unsigned          BULLET_H     = 12,
    parameter int unsigned          SCREEN_H     = 480,
    parameter int unsigned          COOLDOWN     = 20,
    parameter logic [COLR_BITS-1:0] BULLET_COLR  = COLR_BITS'(4'hC)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame,
    input  logic                             fire_req,
    input  logic [SCREEN_CORDW-1:0]          fire_x,
    input  logic [SCREEN_CORDW-1:0]          fire_y,
    output logic                             fire_ack,
    input  logic [7:0]                       speed,
    input  logic [N_SLOTS-1:0]               hit,
    input  logic [SCREEN_CORDW-1:0]          screen_x,
    input  logic [SCREEN_CORDW-1:0]          screen_y,
    output logic [N_SLOTS-1:0]               active,
    output logic [N_SLOTS*SCREEN_CORDW-1:0]  bullet_x,
    output logic [N_SLOTS*SCREEN_CORDW-1:0]  bullet_y,
    output logic                             drawing,
    output logic [COLR_BITS-1:0]             pixel
);

    localparam int unsigned CW  = SCREEN_CORDW;
    localparam int unsigned CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic {S_FREE, S_LIVE} slot_state_t;

    slot_state_t      state_q [N_SLOTS];
    slot_state_t      state_d [N_SLOTS];
    logic [CW-1:0]    x_q     [N_SLOTS];
    logic [CW-1:0]    x_d     [N_SLOTS];
    logic [CW-1:0]    y_q     [N_SLOTS];
    logic [CW-1:0]    y_d     [N_SLOTS];
    logic [CW:0]      y_sum   [N_SLOTS];
    logic [CDW-1:0]   cd_q, cd_d;
    logic             ack_d;
    logic             cover_d;
    logic             alloc_ok;
    logic             taken;

`ifdef ALIEN_BULLET_ZIGZAG_EN
    localparam logic [CW:0] X_MAX = (CW+1)'((64'd1 << CW) - 64'd1 - 64'(BULLET_W));
    logic [1:0]       phase_q [N_SLOTS];
    logic [1:0]       phase_d [N_SLOTS];
    logic             dir_q   [N_SLOTS];
    logic             dir_d   [N_SLOTS];
    logic [CW:0]      x_inc   [N_SLOTS];
`endif

    // Next-state: hits, move/exit, allocation, cooldown, beam cover test
    always_comb begin
        cd_d     = cd_q;
        ack_d    = 1'b0;
        cover_d  = 1'b0;
        taken    = 1'b0;
        alloc_ok = frame && fire_req && (cd_q == '0);

        for (int i = 0; i < int'(N_SLOTS); i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            y_sum[i]   = {1'b0, y_q[i]} + (CW+1)'(speed);
`ifdef ALIEN_BULLET_ZIGZAG_EN
            phase_d[i] = phase_q[i];
            dir_d[i]   = dir_q[i];
            x_inc[i]   = {1'b0, x_q[i]} + (CW+1)'(2);
`endif
            if (state_q[i] == S_LIVE) begin
                if (hit[i]) begin
                    state_d[i] = S_FREE;
                end else if (frame) begin
                    // The wide sum catches both the screen bottom and a carry out
                    if (y_sum[i] >= (CW+1)'(SCREEN_H)) begin
                        state_d[i] = S_FREE;
                    end else begin
                        y_d[i] = y_sum[i][CW-1:0];
`ifdef ALIEN_BULLET_ZIGZAG_EN
                        phase_d[i] = phase_q[i] + 2'd1;
                        if (phase_q[i] == 2'd3) begin
                            dir_d[i] = ~dir_q[i];
                            if (!dir_q[i])
                                x_d[i] = (x_inc[i] > X_MAX) ? X_MAX[CW-1:0] : x_inc[i][CW-1:0];
                            else
                                x_d[i] = (x_q[i] < CW'(2)) ? '0 : x_q[i] - CW'(2);
                        end
`endif
                    end
                end
            end
        end

        // Lowest free slot after this edge's frees takes the shot
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (alloc_ok && !taken && state_d[i] == S_FREE) begin
                state_d[i] = S_LIVE;
                x_d[i]     = fire_x;
                y_d[i]     = fire_y;
`ifdef ALIEN_BULLET_ZIGZAG_EN
                phase_d[i] = 2'd0;
                dir_d[i]   = 1'b0;
`endif
                taken      = 1'b1;
            end
        end

        ack_d = taken;
        if (taken)
            cd_d = CDW'(COOLDOWN);
        else if (frame && cd_q != '0)
            cd_d = cd_q - CDW'(1);

        for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (state_q[i] == S_LIVE
                && screen_x >= x_q[i]
                && {1'b0, screen_x} < {1'b0, x_q[i]} + (CW+1)'(BULLET_W)
                && screen_y >= y_q[i]
                && {1'b0, screen_y} < {1'b0, y_q[i]} + (CW+1)'(BULLET_H))
                cover_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_SLOTS); i++) begin
                state_q[i] <= S_FREE;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
`ifdef ALIEN_BULLET_ZIGZAG_EN
                phase_q[i] <= 2'd0;
                dir_q[i]   <= 1'b0;
`endif
            end
            cd_q     <= '0;
            fire_ack <= 1'b0;
            drawing  <= 1'b0;
            pixel    <= '0;
        end else begin
            for (int i = 0; i < int'(N_SLOTS); i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
`ifdef ALIEN_BULLET_ZIGZAG_EN
                phase_q[i] <= phase_d[i];
                dir_q[i]   <= dir_d[i];
`endif
            end
            cd_q     <= cd_d;
            fire_ack <= ack_d;
            drawing  <= cover_d;
            pixel    <= cover_d ? BULLET_COLR : '0;
        end
    end

    for (genvar g = 0; g < int'(N_SLOTS); g++) begin : g_out
        assign active[g]             = (state_q[g] == S_LIVE);
        assign bullet_x[g*CW +: CW]  = x_q[g];
        assign bullet_y[g*CW +: CW]  = y_q[g];
    end

endmodule

// File: tb/tb_alien_bullet_pool.sv
// Randomised + directed bench for alien_bullet_pool against a behavioural slot-pool model.
module tb_alien_bullet_pool;

    localparam int NS = 4;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame = 1'b0;
    logic              fire_req = 1'b0;
    logic [CW-1:0]     fire_x = '0;
    logic [CW-1:0]     fire_y = '0;
    logic              fire_ack;
    logic [7:0]        speed = '0;
    logic [NS-1:0]     hit = '0;
    logic [CW-1:0]     screen_x = '0;
    logic [CW-1:0]     screen_y = '0;
    logic [NS-1:0]     active;
    logic [NS*CW-1:0]  bullet_x;
    logic [NS*CW-1:0]  bullet_y;
    logic              drawing;
    logic [3:0]        pixel;

    int errors = 0;
    int checks = 0;

    alien_bullet_pool dut (
        .clk(clk), .rst(rst), .frame(frame), .fire_req(fire_req),
        .fire_x(fire_x), .fire_y(fire_y), .fire_ack(fire_ack), .speed(speed),
        .hit(hit), .screen_x(screen_x), .screen_y(screen_y), .active(active),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .drawing(drawing), .pixel(pixel)
    );

    always #5 clk = ~clk;

    // Behavioural model: a list of bullets with integer coordinates
    bit m_live [NS];
    int m_x [NS];
    int m_y [NS];
    int m_cd;
    bit m_ack;
    bit m_draw;
    int ms;
    bit md;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_live[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_cd = 0; m_ack = 0; m_draw = 0;
        end else begin
            md = 0;
            for (int i = 0; i < NS; i++)
                if (m_live[i] && int'(screen_x) >= m_x[i] && int'(screen_x) < m_x[i] + 4
                    && int'(screen_y) >= m_y[i] && int'(screen_y) < m_y[i] + 12)
                    md = 1;
            m_draw = md;
            for (int i = 0; i < NS; i++) begin
                if (hit[i]) m_live[i] = 0;
                else if (frame && m_live[i]) begin
                    ms = m_y[i] + int'(speed);
                    if (ms >= 480) m_live[i] = 0;
                    else m_y[i] = ms;
                end
            end
            m_ack = 0;
            if (frame) begin
                if (fire_req && m_cd == 0)
                    for (int i = 0; i < NS; i++)
                        if (!m_ack && !m_live[i]) begin
                            m_live[i] = 1; m_x[i] = int'(fire_x); m_y[i] = int'(fire_y); m_ack = 1;
                        end
                if (m_ack) m_cd = 20;
                else if (m_cd > 0) m_cd = m_cd - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NS-1:0] av;
        for (int i = 0; i < NS; i++) av[i] = m_live[i];
        check("ack", 32'(fire_ack), 32'(m_ack));
        check("active", 32'(active), 32'(av));
        for (int i = 0; i < NS; i++) begin
            check($sformatf("x%0d", i), 32'(bullet_x[i*CW +: CW]), 32'(m_x[i]));
            check($sformatf("y%0d", i), 32'(bullet_y[i*CW +: CW]), 32'(m_y[i]));
        end
        check("drawing", 32'(drawing), 32'(m_draw));
        check("pixel", 32'(pixel), m_draw ? 32'hC : 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic frame_tick();
        frame = 1'b1; step();
        frame = 1'b0; step();
    endtask

    function automatic int slot_x(input int i);
        return int'(bullet_x[i*CW +: CW]);
    endfunction

    function automatic int slot_y(input int i);
        return int'(bullet_y[i*CW +: CW]);
    endfunction

    int ack_f [$];
    int n;

    initial begin
        // Reset with fire and frame asserted
        rst = 1'b1; fire_req = 1'b1; frame = 1'b1;
        step(); step();
        check("rst_active", 32'(active), 32'h0);
        check("rst_ack", 32'(fire_ack), 32'h0);
        check("rst_draw", 32'(drawing), 32'h0);
        check("rst_pixel", 32'(pixel), 32'h0);
        rst = 1'b0; frame = 1'b0; fire_req = 1'b0;
        step();

        // Fire and move
        fire_x = 16'd100; fire_y = 16'd50; speed = 8'd8; fire_req = 1'b1;
        frame = 1'b1; step();
        check("fire_ack", 32'(fire_ack), 32'h1);
        check("fire_live", 32'(active), 32'h1);
        check("fire_x", 32'(slot_x(0)), 32'd100);
        check("fire_y", 32'(slot_y(0)), 32'd50);
        frame = 1'b0; fire_req = 1'b0; step();
        check("ack_pulse", 32'(fire_ack), 32'h0);
        screen_x = 16'd101; screen_y = 16'd55; step();
        check("draw_in", 32'(drawing), 32'h1);
        check("pixel_in", 32'(pixel), 32'hC);
        screen_x = 16'd104; step();
        check("draw_edge", 32'(drawing), 32'h0);
        screen_x = 16'd0; screen_y = 16'd0;
        repeat (3) frame_tick();
        check("move_y", 32'(slot_y(0)), 32'd74);

        // Cooldown spacing with pool slots available
        speed = 8'd0;
        repeat (25) frame_tick();
        fire_req = 1'b1; fire_x = 16'd30;
        for (int f = 0; f < 43; f++) begin
            frame = 1'b1; step();
            if (fire_ack) ack_f.push_back(f);
            frame = 1'b0; step();
        end
        check("cd_count", 32'(ack_f.size()), 32'd3);
        if (ack_f.size() == 3) begin
            check("cd_f0", 32'(ack_f[0]), 32'd0);
            check("cd_f1", 32'(ack_f[1]), 32'd21);
            check("cd_f2", 32'(ack_f[2]), 32'd42);
        end

        // Pool full: cooldown expires but no slot is free
        n = 0;
        for (int f = 0; f < 22; f++) begin
            frame = 1'b1; step();
            if (fire_ack) n++;
            frame = 1'b0; step();
        end
        check("full_noack", 32'(n), 32'd0);
        hit = 4'b0100; step(); hit = '0;
        check("hit2_free", 32'(active), 32'hB);
        fire_x = 16'd200; fire_y = 16'd60;
        frame = 1'b1; step();
        check("realloc_ack", 32'(fire_ack), 32'h1);
        check("realloc_x2", 32'(slot_x(2)), 32'd200);
        check("realloc_y2", 32'(slot_y(2)), 32'd60);
        frame = 1'b0; fire_req = 1'b0; step();

        // Exit through the bottom of the screen
        hit = 4'hF; step(); hit = '0;
        check("clear_all", 32'(active), 32'h0);
        repeat (20) frame_tick();
        fire_x = 16'd10; fire_y = 16'd470; speed = 8'd8; fire_req = 1'b1;
        frame = 1'b1; step(); frame = 1'b0; fire_req = 1'b0; step();
        check("exit_alloc", 32'(slot_y(0)), 32'd470);
        frame_tick();
        check("exit_y478", 32'(slot_y(0)), 32'd478);
        check("exit_live", 32'(active[0]), 32'h1);
        frame_tick();
        check("exit_free", 32'(active[0]), 32'h0);
        check("exit_hold", 32'(slot_y(0)), 32'd478);
        repeat (20) frame_tick();
        fire_y = 16'd300; speed = 8'd255; fire_req = 1'b1;
        frame = 1'b1; step(); frame = 1'b0; fire_req = 1'b0; step();
        check("fast_alloc", 32'(active[0]), 32'h1);
        frame_tick();
        check("fast_free", 32'(active[0]), 32'h0);
        check("fast_hold", 32'(slot_y(0)), 32'd300);

        // Simultaneous hit and reallocation of slot 0
        speed = 8'd0; fire_req = 1'b1; fire_y = 16'd40;
        for (int f = 0; f < 200 && active != 4'hF; f++) frame_tick();
        check("fill_all", 32'(active), 32'hF);
        repeat (21) frame_tick();
        fire_x = 16'd7; fire_y = 16'd9; speed = 8'd8; hit = 4'b0001;
        frame = 1'b1; step();
        check("sim_ack", 32'(fire_ack), 32'h1);
        check("sim_active", 32'(active), 32'hF);
        check("sim_x0", 32'(slot_x(0)), 32'd7);
        check("sim_y0", 32'(slot_y(0)), 32'd9);
        frame = 1'b0; hit = '0; fire_req = 1'b0; step();

        // Random traffic
        for (int c = 0; c < 6000; c++) begin
            int k;
            rst      = ($urandom_range(0, 999) == 0);
            frame    = ($urandom_range(0, 3) == 0);
            fire_req = ($urandom_range(0, 2) != 0);
            hit      = ($urandom_range(0, 9) == 0) ? NS'($urandom) : '0;
            speed    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 16));
            fire_x   = ($urandom_range(0, 7) == 0) ? CW'($urandom) : CW'($urandom_range(0, 639));
            fire_y   = ($urandom_range(0, 7) == 0) ? CW'($urandom) : CW'($urandom_range(0, 479));
            k        = $urandom_range(0, NS - 1);
            screen_x = CW'(m_x[k] + $urandom_range(0, 6) - 1);
            screen_y = CW'(m_y[k] + $urandom_range(0, 14) - 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
